// File: rtl/agc_gain_ctrl.sv
// ---------------------------------------------------------------------------
// agc_gain_ctrl
//
// Purpose:
//   Closed-loop automatic gain control. Each qualified level measurement is
//   compared against a target. A dead band suppresses small corrections.
//   Outside the dead band the gain code is stepped up or down by a fine or a
//   coarse step and clamped to [GMIN, GMAX]. After every real change, HOLD_N
//   further measurements are skipped so that the analog path can settle
//   before the loop acts again.
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst          asynchronous active-low reset
//   enable       0 blocks new measurements from starting
//   level_valid  one-cycle strobe qualifying level
//   level        measured signal level (DW bits)
//   target       desired level (DW bits)
//   preset_req   forces the gain to GPRESET; wins over everything else
//   gain         registered gain code (GW bits)
//   gain_upd     one-cycle pulse whenever gain actually changes
//   busy         high in any state other than IDLE
//   at_min       gain == GMIN
//   at_max       gain == GMAX
// ---------------------------------------------------------------------------
module agc_gain_ctrl #(
    parameter int DW          = 12,
    parameter int GW          = 12,
    parameter int GMIN        = 1512,
    parameter int GMAX        = 4095,
    parameter int GPRESET     = 1664,
    parameter int DEADBAND    = 16,
    parameter int FINE_STEP   = 1,
    parameter int COARSE_STEP = 16,
    parameter int COARSE_THR  = 256,
    parameter int HOLD_N      = 2,
    parameter int INVERT      = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          level_valid,
    input  logic [DW-1:0] level,
    input  logic [DW-1:0] target,
    input  logic          preset_req,
    output logic [GW-1:0] gain,
    output logic          gain_upd,
    output logic          busy,
    output logic          at_min,
    output logic          at_max
);

    // Elaboration-time sanity checks on the parameter set.
    if (GPRESET < GMIN || GPRESET > GMAX) begin : g_bad_preset
        $error("agc_gain_ctrl: GPRESET must lie within [GMIN, GMAX]");
    end
    if (COARSE_THR <= DEADBAND) begin : g_bad_thr
        $error("agc_gain_ctrl: COARSE_THR must exceed DEADBAND");
    end
    if (GMIN > GMAX) begin : g_bad_range
        $error("agc_gain_ctrl: GMIN must not exceed GMAX");
    end

    // Hold counter must be able to hold HOLD_N; keep at least one bit.
    localparam int HCW = (HOLD_N > 0) ? $clog2(HOLD_N + 1) : 1;

    localparam logic [GW-1:0]  GMIN_W    = GW'(GMIN);
    localparam logic [GW-1:0]  GMAX_W    = GW'(GMAX);
    localparam logic [GW-1:0]  GPRESET_W = GW'(GPRESET);
    localparam logic [GW-1:0]  FINE_W    = GW'(FINE_STEP);
    localparam logic [GW-1:0]  COARSE_W  = GW'(COARSE_STEP);
    localparam logic [DW:0]    DB_W      = (DW+1)'(DEADBAND);
    localparam logic [DW:0]    THR_W     = (DW+1)'(COARSE_THR);
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_N);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);
    localparam logic           INV_BIT   = (INVERT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        APPLY = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state_reg,    state_next;
    logic [GW-1:0]  gain_reg,     gain_next;
    logic           upd_reg,      upd_next;
    logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [DW-1:0]  level_reg,    level_next;
    logic [DW-1:0]  target_reg,   target_next;
    logic [DW:0]    err_mag_reg,  err_mag_next;
    logic           err_neg_reg,  err_neg_next;

    // Error path (used in CALC)
    logic [DW:0]    err_full;
    logic [DW:0]    err_mag_calc;

    // Gain update path (used in APPLY)
    logic [GW-1:0]  step_sel;
    logic [GW:0]    up_sum;
    logic [GW:0]    dn_sum;
    logic [GW:0]    cand;
    logic [GW-1:0]  gain_clamped;
    logic           inc_dir;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            gain_reg     <= GPRESET_W;
            upd_reg      <= 1'b0;
            hold_cnt_reg <= '0;
            level_reg    <= '0;
            target_reg   <= '0;
            err_mag_reg  <= '0;
            err_neg_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gain_reg     <= gain_next;
            upd_reg      <= upd_next;
            hold_cnt_reg <= hold_cnt_next;
            level_reg    <= level_next;
            target_reg   <= target_next;
            err_mag_reg  <= err_mag_next;
            err_neg_reg  <= err_neg_next;
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    always_comb begin
        // Zero-extended subtraction gives a DW+1-bit two's complement error.
        err_full     = {1'b0, target_reg} - {1'b0, level_reg};
        err_mag_calc = err_full[DW] ? ((~err_full) + (DW+1)'(1)) : err_full;

        step_sel = (err_mag_reg >= THR_W) ? COARSE_W : FINE_W;
        inc_dir  = (err_neg_reg == INV_BIT);

        // One extra bit keeps the sum from wrapping; the difference
        // saturates at zero instead of going negative.
        up_sum = {1'b0, gain_reg} + {1'b0, step_sel};
        dn_sum = (gain_reg >= step_sel) ? {1'b0, gain_reg - step_sel} : '0;
        cand   = inc_dir ? up_sum : dn_sum;

        if (cand > {1'b0, GMAX_W}) begin
            gain_clamped = GMAX_W;
        end else if (cand < {1'b0, GMIN_W}) begin
            gain_clamped = GMIN_W;
        end else begin
            gain_clamped = cand[GW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        gain_next     = gain_reg;
        upd_next      = 1'b0;
        hold_cnt_next = hold_cnt_reg;
        level_next    = level_reg;
        target_next   = target_reg;
        err_mag_next  = err_mag_reg;
        err_neg_next  = err_neg_reg;

        if (preset_req) begin
            // Preset overrides any in-flight work and drops a coincident
            // measurement.
            state_next    = IDLE;
            gain_next     = GPRESET_W;
            hold_cnt_next = '0;
            upd_next      = (gain_reg != GPRESET_W);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable && level_valid) begin
                        level_next  = level;
                        target_next = target;
                        state_next  = CALC;
                    end
                end

                CALC: begin
                    err_mag_next = err_mag_calc;
                    err_neg_next = err_full[DW];
                    state_next   = (err_mag_calc <= DB_W) ? IDLE : APPLY;
                end

                APPLY: begin
                    gain_next = gain_clamped;
                    if (gain_clamped != gain_reg) begin
                        upd_next = 1'b1;
                        if (HOLD_N > 0) begin
                            hold_cnt_next = HOLD_INIT;
                            state_next    = HOLD;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        // Clamped no-op: nothing changed, no settling needed.
                        state_next = IDLE;
                    end
                end

                HOLD: begin
                    // Measurements only count down the settle window.
                    if (level_valid) begin
                        if (hold_cnt_reg <= HOLD_ONE) begin
                            hold_cnt_next = '0;
                            state_next    = IDLE;
                        end else begin
                            hold_cnt_next = hold_cnt_reg - HOLD_ONE;
                        end
                    end else if (hold_cnt_reg == '0) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all derived from registers
    // ------------------------------------------------------------------
    assign gain     = gain_reg;
    assign gain_upd = upd_reg;
    assign busy     = (state_reg != IDLE);
    assign at_min   = (gain_reg == GMIN_W);
    assign at_max   = (gain_reg == GMAX_W);

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_agc_gain_ctrl
//
// Purpose:
//   Self-checking bench for agc_gain_ctrl with default parameters. A table of
//   {level, target, expected gain, expected pulse, expected at_min} records
//   is applied in order (the gain carries over between rows), followed by
//   hand-written sequences for hold, preset, enable and reset corner cases.
// ---------------------------------------------------------------------------
module tb_agc_gain_ctrl;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        enable      = 1'b0;
    logic        level_valid = 1'b0;
    logic [11:0] level       = '0;
    logic [11:0] target      = '0;
    logic        preset_req  = 1'b0;
    logic [11:0] gain;
    logic        gain_upd;
    logic        busy;
    logic        at_min;
    logic        at_max;

    agc_gain_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .level_valid (level_valid),
        .level       (level),
        .target      (target),
        .preset_req  (preset_req),
        .gain        (gain),
        .gain_upd    (gain_upd),
        .busy        (busy),
        .at_min      (at_min),
        .at_max      (at_max)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int lv;
        int tg;
        int g;
        int upd;
        int amin;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one measurement; the edge inside this task samples it.
    task automatic meas_start(input int lv, input int tg);
        level       = 12'(lv);
        target      = 12'(tg);
        enable      = 1'b1;
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
    endtask

    // Feed ignored strobes with enable low until the block returns to IDLE.
    task automatic drain();
        enable = 1'b0;
        for (int k = 0; k < 8 && busy; k++) begin
            level_valid = 1'b1;
            tick();
            level_valid = 1'b0;
            tick();
        end
        chk("drain_idle", int'(busy), 0);
        enable = 1'b1;
    endtask

    task automatic apply_vec(input int i);
        meas_start(tbl[i].lv, tbl[i].tg);
        tick();
        tick();
        chk($sformatf("v%0d_gain", i), int'(gain), tbl[i].g);
        chk($sformatf("v%0d_upd", i), int'(gain_upd), tbl[i].upd);
        chk($sformatf("v%0d_busy", i), int'(busy), tbl[i].upd);
        chk($sformatf("v%0d_at_min", i), int'(at_min), tbl[i].amin);
        $display("vec %0d: level=%0d target=%0d gain=%0d upd=%0d", i,
                 tbl[i].lv, tbl[i].tg, gain, gain_upd);
        tick();
        chk($sformatf("v%0d_upd_off", i), int'(gain_upd), 0);
        drain();
    endtask

    initial begin
        // Rows chain: each expected gain starts from the previous row.
        tbl[0] = '{1000, 2000, 1680, 1, 0};  // +1000 coarse up
        tbl[1] = '{1990, 2000, 1680, 0, 0};  // +10 inside dead band
        tbl[2] = '{2000, 1990, 1680, 0, 0};  // -10 inside dead band
        tbl[3] = '{1000, 1017, 1681, 1, 0};  // +17 just outside, fine
        tbl[4] = '{1000, 1016, 1681, 0, 0};  // +16 exactly dead band
        tbl[5] = '{1000, 1255, 1682, 1, 0};  // +255 still fine
        tbl[6] = '{1000, 1256, 1698, 1, 0};  // +256 first coarse
        tbl[7] = '{1300, 1000, 1682, 1, 0};  // -300 coarse down
        tbl[8] = '{1017, 1000, 1681, 1, 0};  // -17 fine down
        // From preset 1664, coarse steps down to the floor.
        for (int k = 0; k < 9; k++) begin
            tbl[9 + k] = '{3000, 2000, 1648 - 16 * k, 1, 0};
        end
        tbl[18] = '{3000, 2000, 1512, 1, 1};  // 1520-16 clamps to GMIN
        tbl[19] = '{3000, 2000, 1512, 0, 1};  // clamped no-op, no pulse

        // Reset
        rst = 1'b0;
        tick();
        chk("rst_gain", int'(gain), 1664);
        chk("rst_busy", int'(busy), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rel_gain", int'(gain), 1664);
        chk("rel_upd", int'(gain_upd), 0);
        chk("rel_busy", int'(busy), 0);
        chk("rel_at_min", int'(at_min), 0);
        chk("rel_at_max", int'(at_max), 0);
        enable = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec(i);

        // Preset from 1681 back to 1664
        preset_req = 1'b1;
        tick();
        preset_req = 1'b0;
        chk("preset_gain", int'(gain), 1664);
        chk("preset_upd", int'(gain_upd), 1);
        chk("preset_busy", int'(busy), 0);
        tick();
        chk("preset_upd_off", int'(gain_upd), 0);

        for (int i = 9; i < 20; i++) apply_vec(i);

        // Hold window: two strobes skipped, third acted on
        meas_start(1000, 2000);
        tick();
        tick();
        chk("hold_chg_gain", int'(gain), 1528);
        chk("hold_chg_upd", int'(gain_upd), 1);
        chk("hold_chg_busy", int'(busy), 1);
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
        tick();
        tick();
        chk("hold_p1_gain", int'(gain), 1528);
        chk("hold_p1_upd", int'(gain_upd), 0);
        chk("hold_p1_busy", int'(busy), 1);
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
        tick();
        tick();
        chk("hold_p2_gain", int'(gain), 1528);
        chk("hold_p2_busy", int'(busy), 0);
        meas_start(1000, 2000);
        tick();
        tick();
        chk("hold_p3_gain", int'(gain), 1544);
        chk("hold_p3_upd", int'(gain_upd), 1);
        $display("hold seq: gain=%0d", gain);
        drain();

        // Strobe during CALC is dropped, not queued
        level       = 12'd1990;
        target      = 12'd2000;
        level_valid = 1'b1;
        tick();
        level = 12'd1000;
        tick();
        level_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("calc_drop_gain", int'(gain), 1544);
        chk("calc_drop_busy", int'(busy), 0);
        $display("calc drop: gain=%0d", gain);

        // enable=0 blocks entry from IDLE
        enable      = 1'b0;
        level       = 12'd1000;
        target      = 12'd2000;
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
        chk("dis_busy", int'(busy), 0);
        tick();
        tick();
        chk("dis_gain", int'(gain), 1544);
        enable = 1'b1;
        $display("enable low: gain=%0d", gain);

        // Preset and strobe together: preset wins, strobe dropped
        preset_req  = 1'b1;
        level_valid = 1'b1;
        tick();
        preset_req  = 1'b0;
        level_valid = 1'b0;
        chk("pv_gain", int'(gain), 1664);
        chk("pv_upd", int'(gain_upd), 1);
        chk("pv_busy", int'(busy), 0);
        tick();
        tick();
        tick();
        chk("pv_after_gain", int'(gain), 1664);
        chk("pv_after_busy", int'(busy), 0);
        $display("preset+valid: gain=%0d", gain);

        // Preset during CALC
        meas_start(1000, 2000);
        tick();
        tick();
        chk("pc_pre_gain", int'(gain), 1680);
        drain();
        meas_start(1000, 2000);
        chk("pc_in_calc", int'(busy), 1);
        preset_req = 1'b1;
        tick();
        preset_req = 1'b0;
        chk("pc_gain", int'(gain), 1664);
        chk("pc_upd", int'(gain_upd), 1);
        chk("pc_busy", int'(busy), 0);
        tick();
        chk("pc_upd_off", int'(gain_upd), 0);
        tick();
        tick();
        chk("pc_final_gain", int'(gain), 1664);
        $display("preset in calc: gain=%0d", gain);

        // Reset mid-flight, then normal measurement
        meas_start(3000, 2000);
        rst = 1'b0;
        #2;
        chk("mrst_gain", int'(gain), 1664);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_upd", int'(gain_upd), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_rel_gain", int'(gain), 1664);
        meas_start(1000, 2000);
        tick();
        tick();
        chk("mrst_meas_gain", int'(gain), 1680);
        chk("mrst_meas_upd", int'(gain_upd), 1);
        $display("reset midflight: gain=%0d", gain);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/agc_gain_ctrl.md
AGC_GAIN_CTRL -- requirements
Module: agc_gain_ctrl

Interface
REQ-001 SHALL provide parameters, one per line as name, default, meaning:
  DW, 12, level and target width
  GW, 12, gain code width
  GMIN, 1512, lowest allowed gain code
  GMAX, 4095, highest allowed gain code
  GPRESET, 1664, reset and preset gain code
  DEADBAND, 16, error magnitude below or equal to which no change is made
  FINE_STEP, 1, step size for small errors
  COARSE_STEP, 16, step size for large errors
  COARSE_THR, 256, error magnitude at or above which COARSE_STEP is used
  HOLD_N, 2, number of measurements ignored after a gain change
  INVERT, 0, 1 swaps the increase/decrease direction
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
  clk, in, 1, single clock
  rst, in, 1, asynchronous active-low reset
  enable, in, 1, 0 ignores measurements
  level_valid, in, 1, one-cycle strobe qualifying level
  level, in, DW, measured signal level (RMS or peak)
  target, in, DW, desired level
  preset_req, in, 1, force gain to GPRESET
  gain, out, GW, registered gain code to DAC
  gain_upd, out, 1, one-cycle pulse when gain changes
  busy, out, 1, high in any state other than IDLE
  at_min, out, 1, gain equals GMIN
  at_max, out, 1, gain equals GMAX
REQ-003 SHALL use one clock (clk) and an asynchronous active-low reset (rst); all state SHALL change on the rising edge of clk only.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, APPLY, HOLD.
REQ-005 IDLE: if enable=1 and level_valid=1, SHALL latch level and target and go to CALC; otherwise SHALL stay in IDLE.
REQ-006 CALC: SHALL compute err = target - level as a signed DW+1-bit value and register |err| and its sign.
REQ-007 CALC exit: if |err| <= DEADBAND, SHALL return to IDLE with no gain change and no pulse; otherwise SHALL go to APPLY.
REQ-008 Step size SHALL be COARSE_STEP when |err| >= COARSE_THR, otherwise FINE_STEP.
REQ-009 Direction (INVERT=0): err>0 SHALL increase gain and err<0 SHALL decrease it; INVERT=1 SHALL reverse this.
REQ-010 APPLY: SHALL compute gain±step in GW+1 bits without wrap, clamp the result to [GMIN, GMAX], and register it into gain.
REQ-011 gain_upd SHALL pulse for exactly one cycle only when the new gain differs from the old; a clamped no-op SHALL produce no pulse.
REQ-012 Latency: level_valid sampled at edge N SHALL yield the updated gain and gain_upd visible after edge N+2.
REQ-013 After APPLY, SHALL go to HOLD if the gain changed and HOLD_N>0; otherwise SHALL go to IDLE.
REQ-014 HOLD: each level_valid SHALL decrement the hold count (loaded with HOLD_N) without acting on it; at count 0 SHALL return to IDLE.
REQ-015 level_valid during CALC or APPLY SHALL be ignored and not queued.
REQ-016 preset_req SHALL have the highest priority in every state: at the next edge gain=GPRESET, state=IDLE, hold count=0, with gain_upd pulsed only if the gain changed.
REQ-017 preset_req and level_valid in the same cycle: the preset SHALL win and the measurement SHALL be dropped.
REQ-018 enable=0 SHALL not abort CALC, APPLY or HOLD already in progress; it SHALL only block new entry from IDLE.
REQ-019 at_min and at_max SHALL be decoded from the gain register only (glitch-free, registered source).
REQ-020 GPRESET SHALL lie within [GMIN, GMAX] and COARSE_THR SHALL exceed DEADBAND; a violation SHALL be a synthesis-time error.

Reset
REQ-021 rst=0 SHALL immediately force: gain=GPRESET, gain_upd=0, busy=0, state=IDLE, hold count=0, latched level/target=0.
REQ-022 Reset asserted mid-CALC, APPLY or HOLD SHALL discard the in-flight measurement; the first measurement after release SHALL be processed normally.

Verification
REQ-023 Reset release -> gain=1664, gain_upd=0, busy=0, at_min=0, at_max=0.
REQ-024 level=1000, target=2000, level_valid pulse -> 2 cycles later gain=1680, gain_upd high for exactly 1 cycle, busy high through HOLD.
REQ-025 level=1990, target=2000 -> no gain change, no gain_upd pulse, back in IDLE after CALC.
REQ-026 Repeated level=3000, target=2000, with HOLD satisfied between measurements -> gain 1648, 1632, ..., 1520, then 1512 with at_min=1; a further measurement produces no pulse.
REQ-027 After the change in REQ-024, next two level_valid pulses are ignored and the third is acted on (HOLD_N=2).
REQ-028 preset_req asserted during CALC -> gain returns to 1664 next edge, gain_upd pulses once, the pending measurement is never applied.
